// File: rtl/wb_master_bridge_if.sv
// Request/response and Wishbone initiator signals of wb_master_bridge.
// The master modport is the bridge's own view. The slave modport is the view of
// the surrounding core and Wishbone target.
interface wb_master_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        input  req_valid, req_we, req_adr, req_dat, req_sel, rsp_ready,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output req_ready, rsp_valid, rsp_dat, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output req_valid, req_we, req_adr, req_dat, req_sel, rsp_ready,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  req_ready, rsp_valid, rsp_dat, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );
endinterface

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer master. It accepts one core request and runs
// one cyc/stb bus cycle. The cycle ends on ack, on err, or on a timeout. The
// bridge then holds the response until the consumer takes it.
module wb_master_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_master_bridge_if.master bus
);

    localparam int unsigned CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          TO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] TMAX = CW'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          cyc_q;
    logic          we_q;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_dat_q;
    logic          rsp_err_q;

    // Bridge FSM: request latch, bus termination, and the held response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        adr_q   <= bus.req_adr;
                        dat_q   <= bus.req_dat;
                        sel_q   <= bus.req_sel;
                        cyc_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    if (bus.wbm_err_i) begin
                        cyc_q       <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_dat_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (bus.wbm_ack_i) begin
                        cyc_q       <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_dat_q   <= we_q ? '0 : bus.wbm_dat_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (TO_EN && (cnt_q == TMAX)) begin
                        cyc_q       <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_dat_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (TO_EN) begin
                        // With the timeout disabled the counter is frozen, so it never wraps.
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Testbench for wb_master_bridge. It runs directed and random transfers against
// a transfer-level reference model. A second instance with the timeout disabled
// is also exercised.
module tb_wb_master_bridge;

    localparam int unsigned TMO = 8;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    wb_master_bridge_if b8 ();
    wb_master_bridge_if b0 ();

    wb_master_bridge #(.TIMEOUT(TMO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (b8)
    );

    wb_master_bridge #(.TIMEOUT(0)) dut_nto (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (b0)
    );

    typedef struct {
        int unsigned occ;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Transfer-level expectation: occupancy and response for a slave that answers
    // with `kind` in bus cycle n.
    function automatic exp_t model(input int kind, input int unsigned n,
                                   input logic we, input logic [31:0] rdat);
        exp_t e;
        if (kind != K_NONE && n <= TMO) begin
            e.occ = n;
            e.err = (kind != K_ACK);
            e.dat = (kind == K_ACK && !we) ? rdat : 32'h0;
        end else begin
            e.occ = TMO;
            e.err = 1'b1;
            e.dat = 32'h0;
        end
        return e;
    endfunction

    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int kind, input int unsigned n,
                          input logic [31:0] rdat, input int unsigned hold);
        exp_t        e;
        int unsigned occ;
        bit          done;
        e    = model(kind, n, we, rdat);
        occ  = 0;
        done = 0;
        @(negedge clk);
        check("req_ready_idle", 32'(b8.req_ready), 32'd1);
        b8.req_valid = 1'b1;
        b8.req_we    = we;
        b8.req_adr   = adr;
        b8.req_dat   = dat;
        b8.req_sel   = sel;
        @(posedge clk);
        #1 b8.req_valid = 1'b0;
        for (int unsigned k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            check("bus_ctl", {28'h0, b8.wbm_cyc_o, b8.wbm_stb_o, b8.wbm_we_o, b8.req_ready},
                  {28'h0, 1'b1, 1'b1, we, 1'b0});
            check("bus_adr", b8.wbm_adr_o, adr);
            check("bus_dat", b8.wbm_dat_o, dat);
            check("bus_sel", 32'(b8.wbm_sel_o), 32'(sel));
            b8.wbm_dat_i = $urandom;
            if (k == n) begin
                b8.wbm_ack_i = (kind == K_ACK || kind == K_BOTH);
                b8.wbm_err_i = (kind == K_ERR || kind == K_BOTH);
                b8.wbm_dat_i = rdat;
            end
            @(posedge clk);
            #1;
            b8.wbm_ack_i = 1'b0;
            b8.wbm_err_i = 1'b0;
            if (!b8.wbm_cyc_o) begin
                occ  = k;
                done = 1;
            end
        end
        check("bus_occupancy", occ, e.occ);
        check("stb_drop", 32'(b8.wbm_stb_o), 32'd0);
        for (int unsigned h = 0; h <= hold; h++) begin
            @(negedge clk);
            check("rsp_valid", 32'(b8.rsp_valid), 32'd1);
            check("rsp_dat", b8.rsp_dat, e.dat);
            check("rsp_err", 32'(b8.rsp_err), 32'(e.err));
            check("req_ready_resp", 32'(b8.req_ready), 32'd0);
            if (h < hold) begin
                // A competing request and a stray ack must both be ignored here.
                b8.rsp_ready = 1'b0;
                b8.req_valid = 1'b1;
                b8.req_adr   = $urandom;
                b8.req_dat   = $urandom;
                b8.wbm_ack_i = 1'b1;
                b8.wbm_dat_i = $urandom;
            end else begin
                b8.rsp_ready = 1'b1;
                b8.req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            b8.wbm_ack_i = 1'b0;
            check("no_accept_in_resp", 32'(b8.wbm_cyc_o), 32'd0);
        end
        b8.rsp_ready = 1'b0;
        b8.req_valid = 1'b0;
        @(negedge clk);
        check("rsp_drop", 32'(b8.rsp_valid), 32'd0);
        check("req_ready_back", 32'(b8.req_ready), 32'd1);
        check("adr_kept", b8.wbm_adr_o, adr);
        check("dat_kept", b8.wbm_dat_o, dat);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {26'h0, b8.wbm_cyc_o, b8.wbm_stb_o, b8.wbm_we_o,
                              b8.rsp_valid, b8.rsp_err, b8.req_ready},
              {26'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        check({tag, "_adr"}, b8.wbm_adr_o, 32'h0);
        check({tag, "_dat"}, b8.wbm_dat_o, 32'h0);
        check({tag, "_sel"}, 32'(b8.wbm_sel_o), 32'h0);
        check({tag, "_rsp_dat"}, b8.rsp_dat, 32'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt;
        b8.req_valid = 0; b8.req_we = 0; b8.req_adr = 0; b8.req_dat = 0; b8.req_sel = 0;
        b8.rsp_ready = 0; b8.wbm_dat_i = 0; b8.wbm_ack_i = 0; b8.wbm_err_i = 0;
        b0.req_valid = 0; b0.req_we = 0; b0.req_adr = 0; b0.req_dat = 0; b0.req_sel = 0;
        b0.rsp_ready = 0; b0.wbm_dat_i = 0; b0.wbm_ack_i = 0; b0.wbm_err_i = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Directed transfers
        do_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, K_ACK, 1, 32'hDEAD_BEEF, 0);
        do_txn(1'b1, 32'h3000_0010, 32'h1234_5678, 4'h3, K_ACK, 4, 32'hCAFE_F00D, 0);
        do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, K_ERR, 2, 32'h5555_AAAA, 0);
        do_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, K_BOTH, 3, 32'h1111_2222, 0);
        do_txn(1'b0, 32'h3000_0028, 32'h0, 4'hF, K_NONE, 1, 32'h0, 0);
        do_txn(1'b0, 32'h3000_002C, 32'h0, 4'hF, K_ACK, 8, 32'h0BAD_CAFE, 0);
        do_txn(1'b0, 32'h3000_0030, 32'h0, 4'hC, K_ACK, 2, 32'hA5A5_5A5A, 5);

        // Stray ack/err in IDLE
        @(negedge clk);
        b8.wbm_ack_i = 1'b1;
        b8.wbm_err_i = 1'b1;
        @(posedge clk);
        #1 b8.wbm_ack_i = 1'b0;
        b8.wbm_err_i = 1'b0;
        @(negedge clk);
        check("idle_ack_ignored", {30'h0, b8.rsp_valid, b8.wbm_cyc_o}, 32'h0);

        // Reset in the 2nd bus cycle
        @(negedge clk);
        b8.req_valid = 1'b1; b8.req_we = 1'b1; b8.req_adr = 32'h4000_0000;
        b8.req_dat = 32'h7777_8888; b8.req_sel = 4'hF;
        @(posedge clk);
        #1 b8.req_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_cyc", 32'(b8.wbm_cyc_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        b8.wbm_ack_i = 1'b1;
        b8.wbm_dat_i = 32'hFFFF_0000;
        @(posedge clk);
        #1 b8.wbm_ack_i = 1'b0;
        @(negedge clk);
        check("midrst_late_ack", {30'h0, b8.rsp_valid, b8.wbm_cyc_o}, 32'h0);

        // Randomized transfers against the model
        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), $urandom_range(1, 10), $urandom,
                   $urandom_range(0, 3));
        end

        // Timeout disabled: a silent slave keeps the cycle open
        @(negedge clk);
        b0.req_valid = 1'b1;
        b0.req_adr   = 32'h5000_0000;
        @(posedge clk);
        #1 b0.req_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (b0.wbm_cyc_o && !b0.rsp_valid) cnt++;
        end
        check("no_timeout_cycles", cnt, 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Wishbone classic single-transfer master driving the initiator side of the same 32-bit Wishbone bus that the user project answers as a slave. An internal core issues requests over a valid/ready port. The bridge runs one bus cycle (`cyc`/`stb`) per request, waits for `ack`, `err` or a timeout, then returns a held response. It sits between the ppcpu core and any Wishbone target, and is the master counterpart to the `wbs_*` slave port.

## Interface
- `TIMEOUT`, 255: maximum number of bus cycles to wait for `ack`/`err`; 0 disables the timeout.
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: synchronous reset, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: bridge can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_adr` in 32: byte address.
- `req_dat` in 32: write data.
- `req_sel` in 4: byte lanes.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_dat` out 32: read data (0 for writes).
- `rsp_err` out 1: the transfer ended by `err` or by timeout.
- `wbm_cyc_o` out 1: Wishbone `cyc`.
- `wbm_stb_o` out 1: Wishbone `stb`.
- `wbm_we_o` out 1: Wishbone `we`.
- `wbm_adr_o` out 32: Wishbone address.
- `wbm_dat_o` out 32: Wishbone write data.
- `wbm_sel_o` out 4: Wishbone byte select.
- `wbm_dat_i` in 32: read data from the slave.
- `wbm_ack_i` in 1: slave acknowledge.
- `wbm_err_i` in 1: slave error.

## Operation
- FSM has three states: IDLE, BUS, RESP. Reset enters IDLE.
- IDLE:
  - `req_ready`=1.
  - When `req_valid` is high: latch `req_we/adr/dat/sel` into `wbm_we_o/adr_o/dat_o/sel_o`, set `wbm_cyc_o`=`wbm_stb_o`=1, clear the timeout counter, go to BUS.
- BUS:
  - `req_ready`=0. `cyc`, `stb` and all `wbm_*_o` are held constant.
  - Each edge checks, in priority order:
    - `wbm_err_i`=1: `rsp_err`=1, `rsp_dat`=0.
    - `wbm_ack_i`=1: `rsp_err`=0, `rsp_dat`=`wbm_dat_i` if read, else 0.
    - Counter equals `TIMEOUT`-1 and `TIMEOUT`≠0: `rsp_err`=1, `rsp_dat`=0.
    - Otherwise increment the counter and stay in BUS.
  - On any of the three terminations: drop `cyc`/`stb` at that same edge and go to RESP.
  - If `ack` and `err` arrive together, `err` wins.
- RESP:
  - `rsp_valid`=1. `rsp_dat` and `rsp_err` are stable.
  - When `rsp_ready` is high: go to IDLE, `rsp_valid`=0 next cycle.
  - No new request is accepted while in RESP.
- `wbm_adr_o/dat_o/sel_o/we_o` keep their last values after the transfer; they change only when a request is accepted.
- Timeout counter width is `$clog2(TIMEOUT+1)`. It does not wrap because it terminates at `TIMEOUT`-1.

## Timing
- Reset (synchronous, takes effect at the edge with `wb_rst_i`=1):
  - `wbm_cyc_o`=`wbm_stb_o`=`wbm_we_o`=0; `wbm_adr_o`=`wbm_dat_o`=0; `wbm_sel_o`=0.
  - `rsp_valid`=0, `rsp_dat`=0, `rsp_err`=0; state IDLE.
  - `req_ready` reads 1 from the first cycle after reset.
- Reset during BUS or RESP abandons the transfer: `cyc`/`stb` fall at that edge and no response is produced.
- `req_ready` is a function of state only; it does not combinationally depend on `req_valid`.
- Latency, with a request accepted at edge E0:
  - `cyc`/`stb` are high in the cycle after E0.
  - `ack` sampled at edge E1 → `rsp_valid` high in the cycle after E1.
  - Minimum request-to-`rsp_valid` is 2 edges.
- Bus occupancy is exactly N cycles for an `ack` in the Nth bus cycle. It is `TIMEOUT` cycles on timeout.
- With `rsp_ready` held high, back-to-back throughput is one transfer per (N+2) cycles: one cycle in RESP and one in IDLE.
- `ack`/`err` seen while not in BUS are ignored.

## Test plan
- Single read: `req` adr=0x3000_0004, we=0; slave acks in the 1st bus cycle with 0xDEADBEEF. Expect:
  - `cyc`/`stb` high for exactly 1 cycle.
  - `rsp_valid` 2 edges after acceptance, `rsp_dat`=0xDEADBEEF, `rsp_err`=0.
- Write with wait states: we=1, dat=0x12345678, sel=0x3, `ack` after 4 cycles. Expect:
  - `adr`/`dat`/`sel`/`we` stable for all 4 cycles.
  - `rsp_dat`=0, `rsp_err`=0.
- Error and collision: slave raises `err` alone → `rsp_err`=1. Slave raises `ack` and `err` in the same cycle → `rsp_err`=1, `rsp_dat`=0.
- Timeout: `TIMEOUT`=8, silent slave. Expect `cyc` high for exactly 8 cycles, then `rsp_err`=1. Also check `TIMEOUT`=0 waits indefinitely (1000 cycles, no response).
- Backpressure and back-to-back: hold `rsp_ready`=0 for 5 cycles. Expect `rsp_valid` and data held and `req_ready`=0 throughout; the next `req_valid` is accepted only after the response handshake.
- Reset mid-transfer: assert `wb_rst_i` in the 2nd BUS cycle. Expect:
  - `cyc`/`stb`/`rsp_valid` are 0 on the next cycle and all outputs are at their reset values.
  - A later `ack` produces no response.
